// File: rtl/decode_pkg.sv
// Shared decode types for the RV32I decode stage: ALU ops, opcodes, field layout,
// the control bundle carried to execute, and immediate/ALU helper functions.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Field order mirrors the instruction word, so a cast of the raw word unpacks it.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic [4:0] rd;
    logic       rd_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src_imm;
    logic       illegal;
    logic [2:0] funct3;
  } ctrl_t;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 architectural register file: two combinational reads, one write port,
// x0 reads as zero and is never written.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : regs[rd_addr_b];

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: edge-detected accept into a 2-entry queue, decode of the
// queue head, load-use bubble insertion, and the output register feeding execute.
module instruction_decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_wb_enable,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_stall_fetch,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd,
  output logic        o_rd_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_branch,
  output logic        o_jump,
  output logic        o_alu_src_imm,
  output logic        o_illegal,
  output logic [2:0]  o_funct3
);

  logic          valid_q;
  logic [31:0]   fifo_instr [2];
  logic [31:0]   fifo_pc    [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic          accept, push, issue, hazard, uses_rs2;
  logic [31:0]   head_instr, head_pc, imm, rf_a, rf_b, rs1_val, rs2_val;
  instr_fields_t f;
  ctrl_t         dec;

  logic          vld_p1;
  ctrl_t         ctrl_p1;
  logic [31:0]   pc_p1, imm_p1, rs1_p1, rs2_p1;

  // Fetch holds valid while idle, so only a rising edge is a new instruction.
  assign accept = i_instruction_valid & ~valid_q;
  assign push   = accept & ~i_flush & (count != 2'd2);

  assign head_instr = fifo_instr[rd_ptr];
  assign head_pc    = fifo_pc[rd_ptr];
  assign f          = instr_fields_t'(head_instr);

  always_comb begin
    dec        = '0;
    imm        = '0;
    dec.rd     = f.rd;
    dec.funct3 = f.funct3;
    case (f.opcode)
      OPC_LUI:    begin dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1; dec.rd_write = 1'b1; imm = imm_u(head_instr); end
      OPC_AUIPC:  begin dec.alu_src_imm = 1'b1; dec.rd_write = 1'b1; imm = imm_u(head_instr); end
      OPC_JAL:    begin dec.jump = 1'b1; dec.rd_write = 1'b1; imm = imm_j(head_instr); end
      OPC_JALR:   begin dec.jump = 1'b1; dec.rd_write = 1'b1; dec.alu_src_imm = 1'b1; imm = imm_i(head_instr); end
      OPC_BRANCH: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; imm = imm_b(head_instr); end
      OPC_LOAD:   begin dec.mem_read = 1'b1; dec.rd_write = 1'b1; dec.alu_src_imm = 1'b1; imm = imm_i(head_instr); end
      OPC_STORE:  begin dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1; imm = imm_s(head_instr); end
      OPC_OP_IMM: begin
        dec.rd_write    = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm             = imm_i(head_instr);
        // Bit 30 is part of the immediate except for the shift-right pair.
        dec.alu_op      = alu_from_funct3(f.funct3, (f.funct3 == 3'b101) & f.funct7[5]);
        if (f.funct3 == 3'b001 && f.funct7 != 7'h00) dec.illegal = 1'b1;
        if (f.funct3 == 3'b101 && f.funct7 != 7'h00 && f.funct7 != 7'h20) dec.illegal = 1'b1;
      end
      OPC_OP: begin
        dec.rd_write = 1'b1;
        dec.alu_op   = alu_from_funct3(f.funct3, f.funct7[5]);
        if (!(f.funct7 == 7'h00 ||
              (f.funct7 == 7'h20 && (f.funct3 == 3'b000 || f.funct3 == 3'b101))))
          dec.illegal = 1'b1;
      end
      OPC_FENCE: ;
      default:   dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.rd_write  = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
    if (f.rd == 5'd0) dec.rd_write = 1'b0;
  end

  assign uses_rs2 = (f.opcode == OPC_OP) | (f.opcode == OPC_STORE) | (f.opcode == OPC_BRANCH);
  assign hazard   = vld_p1 & ctrl_p1.mem_read & (ctrl_p1.rd != 5'd0) &
                    ((f.rs1 == ctrl_p1.rd) | (uses_rs2 & (f.rs2 == ctrl_p1.rd)));
  assign issue    = (count != 2'd0) & ~i_stall & ~hazard;

  register_file u_rf (
    .clk       (clk),
    .rst       (reset),
    .wr_en     (i_wb_enable),
    .wr_addr   (i_wb_rd),
    .wr_data   (i_wb_data),
    .rd_addr_a (f.rs1),
    .rd_data_a (rf_a),
    .rd_addr_b (f.rs2),
    .rd_data_b (rf_b)
  );

  assign rs1_val = (i_wb_enable && i_wb_rd != 5'd0 && i_wb_rd == f.rs1) ? i_wb_data : rf_a;
  assign rs2_val = (i_wb_enable && i_wb_rd != 5'd0 && i_wb_rd == f.rs2) ? i_wb_data : rf_b;

  // Stage p0: instruction queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
    end else begin
      valid_q <= i_instruction_valid;
      if (i_flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push)  wr_ptr <= ~wr_ptr;
        if (issue) rd_ptr <= ~rd_ptr;
        case ({push, issue})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= i_instruction;
      fifo_pc[wr_ptr]    <= i_pc;
    end
  end

  // Stage p1: output register to execute
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      pc_p1   <= '0;
      imm_p1  <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
    end else if (i_flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (!i_stall) begin
      if (issue) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= dec;
        pc_p1   <= head_pc;
        imm_p1  <= imm;
        rs1_p1  <= rs1_val;
        rs2_p1  <= rs2_val;
      end else begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end
    end
  end

  assign o_stall_fetch = (count != 2'd0) | i_stall;
  assign o_valid       = vld_p1;
  assign o_pc          = pc_p1;
  assign o_alu_op      = ctrl_p1.alu_op;
  assign o_rs1_data    = rs1_p1;
  assign o_rs2_data    = rs2_p1;
  assign o_imm         = imm_p1;
  assign o_rd          = ctrl_p1.rd;
  assign o_rd_write    = ctrl_p1.rd_write;
  assign o_mem_read    = ctrl_p1.mem_read;
  assign o_mem_write   = ctrl_p1.mem_write;
  assign o_branch      = ctrl_p1.branch;
  assign o_jump        = ctrl_p1.jump;
  assign o_alu_src_imm = ctrl_p1.alu_src_imm;
  assign o_illegal     = ctrl_p1.illegal;
  assign o_funct3      = ctrl_p1.funct3;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-encoded RV32I words with
// hand-computed decode results, hazards, bypass, stall, flush and reset.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_instruction;
  logic        i_instruction_valid;
  logic [31:0] i_pc;
  logic        i_stall;
  logic        i_flush;
  logic        i_wb_enable;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_stall_fetch, o_valid;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_rd;
  logic        o_rd_write, o_mem_read, o_mem_write, o_branch, o_jump, o_alu_src_imm, o_illegal;
  logic [2:0]  o_funct3;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] ADDI_X1_M5   = 32'hFFB00093;
  localparam logic [31:0] LW_X2_X1     = 32'h0000A103;
  localparam logic [31:0] ADD_X3_X2_X2 = 32'h002101B3;
  localparam logic [31:0] ADD_X3_X1_X1 = 32'h001081B3;
  localparam logic [31:0] ADD_X6_X5_X0 = 32'h00028333;
  localparam logic [31:0] ADD_X7_X5_X5 = 32'h005283B3;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
  localparam logic [31:0] ADD_X10_X9   = 32'h00048533;
  localparam logic [31:0] LUI_X4       = 32'h80000237;
  localparam logic [31:0] BEQ_M4       = 32'hFE208EE3;
  localparam logic [31:0] SW_M8        = 32'hFE20AC23;
  localparam logic [31:0] BAD_OPC      = 32'h00000FFF;

  instruction_decode dut (
    .clk                 (clk),
    .reset               (reset),
    .i_instruction       (i_instruction),
    .i_instruction_valid (i_instruction_valid),
    .i_pc                (i_pc),
    .i_stall             (i_stall),
    .i_flush             (i_flush),
    .i_wb_enable         (i_wb_enable),
    .i_wb_rd             (i_wb_rd),
    .i_wb_data           (i_wb_data),
    .o_stall_fetch       (o_stall_fetch),
    .o_valid             (o_valid),
    .o_pc                (o_pc),
    .o_alu_op            (o_alu_op),
    .o_rs1_data          (o_rs1_data),
    .o_rs2_data          (o_rs2_data),
    .o_imm               (o_imm),
    .o_rd                (o_rd),
    .o_rd_write          (o_rd_write),
    .o_mem_read          (o_mem_read),
    .o_mem_write         (o_mem_write),
    .o_branch            (o_branch),
    .o_jump              (o_jump),
    .o_alu_src_imm       (o_alu_src_imm),
    .o_illegal           (o_illegal),
    .o_funct3            (o_funct3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [31:0] instr, input logic [31:0] pc);
    i_instruction       = instr;
    i_pc                = pc;
    i_instruction_valid = 1'b1;
    step();
    i_instruction_valid = 1'b0;
    step();
  endtask

  task automatic send_accept(input logic [31:0] instr, input logic [31:0] pc);
    i_instruction       = instr;
    i_pc                = pc;
    i_instruction_valid = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; i_instruction = '0; i_instruction_valid = 1'b0; i_pc = '0;
    i_stall = 1'b0; i_flush = 1'b0; i_wb_enable = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    step(); step();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_stall_fetch", 32'(o_stall_fetch), 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_imm", o_imm, 0);
    chk("rst_alu_op", 32'(o_alu_op), 0);
    reset = 1'b0;
    step();

    // ADDI x1,x0,-5: two edges from the valid edge to o_valid
    send_accept(ADDI_X1_M5, 32'h0);
    i_instruction_valid = 1'b0;
    chk("addi_lat1_valid", 32'(o_valid), 0);
    chk("addi_lat1_stall_fetch", 32'(o_stall_fetch), 1);
    step();
    chk("addi_valid", 32'(o_valid), 1);
    chk("addi_imm", o_imm, 32'hFFFFFFFB);
    chk("addi_alu_op", 32'(o_alu_op), 0);
    chk("addi_src_imm", 32'(o_alu_src_imm), 1);
    chk("addi_rd", 32'(o_rd), 1);
    chk("addi_rd_write", 32'(o_rd_write), 1);
    chk("addi_pc", o_pc, 0);
    chk("addi_stall_fetch", 32'(o_stall_fetch), 0);

    // Stall while LW x2 and ADD x3,x2,x2 queue up, then release: one bubble
    i_stall = 1'b1;
    send_accept(LW_X2_X1, 32'h4);
    i_instruction_valid = 1'b0;
    step();
    send_accept(ADD_X3_X2_X2, 32'h8);
    i_instruction_valid = 1'b0;
    chk("stall_hold_valid", 32'(o_valid), 1);
    chk("stall_hold_pc", o_pc, 0);
    chk("stall_hold_rd", 32'(o_rd), 1);
    chk("stall_fetch_full", 32'(o_stall_fetch), 1);
    i_stall = 1'b0;
    step();
    chk("lw_valid", 32'(o_valid), 1);
    chk("lw_pc", o_pc, 32'h4);
    chk("lw_mem_read", 32'(o_mem_read), 1);
    chk("lw_rd", 32'(o_rd), 2);
    chk("lw_imm", o_imm, 0);
    step();
    chk("hazard_bubble_valid", 32'(o_valid), 0);
    chk("hazard_bubble_mem_read", 32'(o_mem_read), 0);
    chk("hazard_bubble_rd_write", 32'(o_rd_write), 0);
    step();
    chk("add_after_bubble_valid", 32'(o_valid), 1);
    chk("add_after_bubble_pc", o_pc, 32'h8);
    chk("add_after_bubble_src", 32'(o_alu_src_imm), 0);
    chk("add_after_bubble_rd", 32'(o_rd), 3);
    chk("queue_drained", 32'(o_stall_fetch), 0);

    // Hazard-free load pair: no bubble
    i_stall = 1'b1;
    send_accept(LW_X2_X1, 32'hC);
    i_instruction_valid = 1'b0;
    step();
    send_accept(ADD_X3_X1_X1, 32'h10);
    i_instruction_valid = 1'b0;
    i_stall = 1'b0;
    step();
    chk("nohaz_lw_pc", o_pc, 32'hC);
    step();
    chk("nohaz_add_valid", 32'(o_valid), 1);
    chk("nohaz_add_pc", o_pc, 32'h10);
    step();
    chk("empty_bubble_valid", 32'(o_valid), 0);

    // Writeback bypass in the issue cycle
    send_accept(ADD_X6_X5_X0, 32'h14);
    i_instruction_valid = 1'b0;
    i_wb_enable = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'hDEADBEEF;
    step();
    i_wb_enable = 1'b0;
    chk("bypass_valid", 32'(o_valid), 1);
    chk("bypass_rs1", o_rs1_data, 32'hDEADBEEF);
    chk("bypass_rs2_x0", o_rs2_data, 0);
    chk("bypass_rd", 32'(o_rd), 6);
    issue_one(ADD_X7_X5_X5, 32'h18);
    chk("rf_x5_rs1", o_rs1_data, 32'hDEADBEEF);
    chk("rf_x5_rs2", o_rs2_data, 32'hDEADBEEF);
    send_accept(ADD_X6_X0_X0, 32'h1C);
    i_instruction_valid = 1'b0;
    i_wb_enable = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h12345678;
    step();
    i_wb_enable = 1'b0;
    chk("x0_no_bypass", o_rs1_data, 0);
    issue_one(ADD_X6_X0_X0, 32'h20);
    chk("x0_read_rs1", o_rs1_data, 0);
    chk("x0_read_rs2", o_rs2_data, 0);

    // Immediate formats and control decode
    issue_one(LUI_X4, 32'h24);
    chk("lui_imm", o_imm, 32'h80000000);
    chk("lui_alu_op", 32'(o_alu_op), 10);
    chk("lui_rd", 32'(o_rd), 4);
    chk("lui_rd_write", 32'(o_rd_write), 1);
    issue_one(BEQ_M4, 32'h28);
    chk("beq_imm", o_imm, 32'hFFFFFFFC);
    chk("beq_branch", 32'(o_branch), 1);
    chk("beq_rd_write", 32'(o_rd_write), 0);
    chk("beq_alu_op", 32'(o_alu_op), 1);
    issue_one(SW_M8, 32'h2C);
    chk("sw_imm", o_imm, 32'hFFFFFFF8);
    chk("sw_mem_write", 32'(o_mem_write), 1);
    chk("sw_rd_write", 32'(o_rd_write), 0);
    chk("sw_funct3", 32'(o_funct3), 2);

    // Flush with two queued and a live output; accept and writeback in the same cycle
    issue_one(ADDI_X1_M5, 32'h30);
    chk("preflush_valid", 32'(o_valid), 1);
    i_stall = 1'b1;
    send_accept(LUI_X4, 32'h34);
    i_instruction_valid = 1'b0;
    step();
    send_accept(SW_M8, 32'h38);
    i_instruction_valid = 1'b0;
    step();
    chk("preflush_stall_fetch", 32'(o_stall_fetch), 1);
    chk("preflush_hold_valid", 32'(o_valid), 1);
    i_flush = 1'b1; i_stall = 1'b0;
    i_instruction = ADDI_X1_M5; i_pc = 32'h3C; i_instruction_valid = 1'b1;
    i_wb_enable = 1'b1; i_wb_rd = 5'd9; i_wb_data = 32'hCAFEF00D;
    step();
    i_flush = 1'b0; i_instruction_valid = 1'b0; i_wb_enable = 1'b0;
    chk("flush_valid", 32'(o_valid), 0);
    chk("flush_rd_write", 32'(o_rd_write), 0);
    chk("flush_fifo_empty", 32'(o_stall_fetch), 0);
    step();
    chk("flush_accept_dropped", 32'(o_valid), 0);
    issue_one(ADD_X10_X9, 32'h100);
    chk("postflush_valid", 32'(o_valid), 1);
    chk("postflush_pc", o_pc, 32'h100);
    chk("flush_wb_committed", o_rs1_data, 32'hCAFEF00D);

    // Illegal opcode with valid held for four edges: one accept only
    send_accept(BAD_OPC, 32'h200);
    chk("illegal_lat1_valid", 32'(o_valid), 0);
    step();
    chk("illegal_valid", 32'(o_valid), 1);
    chk("illegal_flag", 32'(o_illegal), 1);
    chk("illegal_rd_write", 32'(o_rd_write), 0);
    chk("illegal_rd", 32'(o_rd), 31);
    step();
    chk("held_valid_edge3", 32'(o_valid), 0);
    step();
    chk("held_valid_edge4", 32'(o_valid), 0);
    chk("held_valid_fifo_empty", 32'(o_stall_fetch), 0);
    i_instruction_valid = 1'b0;
    step();
    chk("held_valid_after", 32'(o_valid), 0);

    // Asynchronous reset in mid-cycle
    issue_one(ADDI_X1_M5, 32'h300);
    chk("prereset_valid", 32'(o_valid), 1);
    reset = 1'b1;
    #2;
    chk("async_rst_valid", 32'(o_valid), 0);
    chk("async_rst_pc", o_pc, 0);
    chk("async_rst_imm", o_imm, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_valid", 32'(o_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the RV32I core, directly downstream of instruction fetch. It takes fetched instructions with their PC, buffers them in a 2-entry queue, and decodes them into control fields, a sign-extended immediate and register operands from an internal register file. It detects load-use hazards and inserts bubbles, and registers the result for the execute stage. It also back-pressures fetch through a stall output.

## Interface
- No parameters; data path fixed at 32 bits, 32 architectural registers.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_instruction  in  32  instruction word from fetch
- i_instruction_valid  in  1  fetch valid; may stay high for several cycles per instruction
- i_pc  in  32  PC of i_instruction
- i_stall  in  1  execute cannot accept; hold output register
- i_flush  in  1  taken branch/jump; discard everything held
- i_wb_enable / i_wb_rd / i_wb_data  in  1/5/32  register write port from writeback
- o_stall_fetch  out  1  to fetch i_stall
- o_valid  out  1  output register holds a real instruction
- o_pc  out  32  PC of decoded instruction
- o_alu_op  out  4  alu_op_t
- o_rs1_data, o_rs2_data  out  32  operands; o_imm  out  32  sign-extended immediate
- o_rd  out  5; o_rd_write, o_mem_read, o_mem_write, o_branch, o_jump, o_alu_src_imm, o_illegal  out  1 each
- o_funct3  out  3  width/branch condition for later stages

## Operation
- Accept: one instruction is accepted per rising edge of i_instruction_valid (valid high and registered valid_q low). This is not level-triggered, because fetch holds valid across its idle state.
- Queue: 2-entry FIFO of {instruction, pc}. o_stall_fetch = (count != 0) | i_stall. Fetch has at most one read in flight, so 2 entries cannot overflow. A write when full is dropped, and the bench flags it as an error.
- Issue: the head is issued when the FIFO is non-empty, i_stall = 0 and there is no hazard. An accept and an issue in the same cycle are allowed, and the count is unchanged.
- Hazard: o_valid & o_mem_read & o_rd != 0, and the head reads o_rd (rs1, or rs2 for R/S/B types). Outcome: the head is not popped, and the output register loads a bubble (o_valid = 0, all control bits 0). The next cycle issues normally.
- i_stall = 1: the output register and FIFO hold. Accepts still happen.
- i_flush: synchronous. The FIFO is emptied, o_valid is cleared to 0 and the control bits are cleared. An accept in the same cycle is discarded. Flush has priority over stall and hazard.
- Decode, by opcode: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (treated as NOP).
  - Any other opcode, or bad funct7: o_illegal = 1 and o_rd_write/o_mem_* = 0.
  - Immediates use I/S/B/U/J formats, sign-extended from bit 31. The U-type low 12 bits are 0. The B/J bit 0 is 0.
  - rd == x0 forces o_rd_write = 0.
- Register file: x0 reads 0 and ignores writes. Writeback bypass: if i_wb_enable and i_wb_rd == rs (nonzero), the operand takes i_wb_data in the same cycle.

## Timing
- Reset values:
  - all outputs 0, except o_stall_fetch = 0
  - FIFO empty, valid_q = 0
  - all 32 registers 0
- Latency: valid rising edge at cycle N → entry in FIFO at N+1 → earliest o_valid at N+2 (issue at N+1 edge when FIFO was empty: bypass not provided).
- Reset mid-operation discards the FIFO and output immediately (asynchronous).
- Simultaneous flush and writeback: the register write still commits.

## Structure
- decode_pkg: alu_op_t (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), opcode constants, and an instr_fields_t struct.
- Sub-module register_file: 32×32, two combinational reads, one write, asynchronous reset, x0 hardwired. The bypass mux lives in instruction_decode.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093) at pc 0x0: o_valid = 1 two cycles after the valid edge, o_imm = 0xFFFFFFFB, o_alu_op = ADD, o_alu_src_imm = 1, o_rd = 1, o_rd_write = 1.
- LW x2,0(x1) then ADD x3,x2,x2: exactly one bubble cycle (o_valid = 0) between them; a second hazard-free pair shows no bubble.
- i_wb_enable = 1, rd = 5, data 0xDEADBEEF, in the same cycle as issuing ADD x6,x5,x0: o_rs1_data = 0xDEADBEEF. A write to x0 later reads 0.
- Hold i_stall for 3 cycles while 2 instructions arrive: FIFO fills to 2 with no drop, o_stall_fetch = 1, outputs unchanged; on release the instructions issue in order.
- i_flush with 2 queued and o_valid = 1: next cycle o_valid = 0 and the FIFO is empty; the next accepted instruction issues normally.
- Opcode 0x7F: o_illegal = 1, o_rd_write = 0. Valid held high for 4 cycles yields exactly one accept.
